// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU select codes, flag and EX/MEM control types,
// and the N/Z/C/V derivation used at the execute boundary.
package cpu_pkg;

  localparam int CPU_WIDTH    = 64;
  localparam int CPU_REG_BITS = 5;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'b000,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_AND    = 3'b100,
    ALU_OR     = 3'b101,
    ALU_XOR    = 3'b110
  } alu_sel_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef struct packed {
    logic                    valid;
    logic [CPU_REG_BITS-1:0] rd;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
  } exmem_ctrl_t;

  // C and V only carry meaning for arithmetic; sub carry is NOT borrow as produced by the slices.
  function automatic flags_t derive_flags(input logic msb, input logic zero,
                                          input logic cout_msb, input logic cin_msb,
                                          input logic [2:0] sel);
    flags_t f;
    f.n = msb;
    f.z = zero;
    case (sel)
      ALU_ADD, ALU_SUB: begin
        f.c = cout_msb;
        f.v = cout_msb ^ cin_msb;
      end
      default: begin
        f.c = 1'b0;
        f.v = 1'b0;
      end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ex_mem_flag_stage_if.sv
// EX-side inputs and MEM-side outputs of the EX/MEM flag stage.
interface ex_mem_flag_stage_if #(
  parameter int WIDTH    = 64,
  parameter int REG_BITS = 5
);
  logic [WIDTH-1:0]    alu_result;
  logic                alu_cout_msb;
  logic                alu_cin_msb;
  logic [2:0]          alu_select;
  logic                ex_valid;
  logic                ex_set_flags;
  logic [REG_BITS-1:0] ex_rd;
  logic                ex_reg_write;
  logic                ex_mem_read;
  logic                ex_mem_write;
  logic [WIDTH-1:0]    ex_store_data;
  logic                stall;
  logic                flush;

  logic                ex_zero;
  logic [3:0]          flags_fwd;
  logic [3:0]          flags;
  logic                mem_valid;
  logic [REG_BITS-1:0] mem_rd;
  logic                mem_reg_write;
  logic                mem_mem_read;
  logic                mem_mem_write;
  logic [WIDTH-1:0]    mem_result;
  logic [WIDTH-1:0]    mem_store_data;

  modport master (
    output alu_result, alu_cout_msb, alu_cin_msb, alu_select, ex_valid, ex_set_flags,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, stall, flush,
    input  ex_zero, flags_fwd, flags, mem_valid, mem_rd, mem_reg_write, mem_mem_read,
           mem_mem_write, mem_result, mem_store_data
  );

  modport slave (
    input  alu_result, alu_cout_msb, alu_cin_msb, alu_select, ex_valid, ex_set_flags,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, stall, flush,
    output ex_zero, flags_fwd, flags, mem_valid, mem_rd, mem_reg_write, mem_mem_read,
           mem_mem_write, mem_result, mem_store_data
  );
endinterface

// File: rtl/zero_detect.sv
// Result-is-zero detector: a first rank of 2-input NORs feeding an AND reduction.
// WIDTH is expected to be even.
module zero_detect #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH/2-1:0] pair_nor;

  for (genvar i = 0; i < WIDTH/2; i++) begin : g_pair
    assign pair_nor[i] = ~(value[2*i] | value[2*i+1]);
  end

  assign zero = &pair_nor;

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM boundary: flag derivation, architectural flag register with bypass,
// and the EX/MEM pipeline register with flush > stall > load priority.
module ex_mem_flag_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH    = CPU_WIDTH,
  parameter int REG_BITS = CPU_REG_BITS
) (
  input logic               clk,
  input logic               reset,
  ex_mem_flag_stage_if.slave bus
);

  logic             ex_zero;
  flags_t           derived;
  flags_t           flags_r;
  exmem_ctrl_t      ctrl_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] store_r;
  logic             set_flags_now;
  logic             flag_write;

  zero_detect #(.WIDTH(WIDTH)) u_zero_detect (
    .value (bus.alu_result),
    .zero  (ex_zero)
  );

  assign set_flags_now = bus.ex_valid & bus.ex_set_flags;
  assign flag_write    = set_flags_now & ~bus.stall & ~bus.flush;

  // Derived flags of the instruction currently in EX.
  always_comb begin
    derived = derive_flags(bus.alu_result[WIDTH-1], ex_zero, bus.alu_cout_msb,
                           bus.alu_cin_msb, bus.alu_select);
  end

  // Bypass lets a B.cond right behind a flag-setter see the new flags.
  always_comb begin
    if (set_flags_now) begin
      bus.flags_fwd = derived;
    end else begin
      bus.flags_fwd = flags_r;
    end
  end

  // Architectural flag register; stalled or flushed setters never commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_r <= '0;
    end else if (flag_write) begin
      flags_r <= derived;
    end else begin
      flags_r <= flags_r;
    end
  end

  // EX/MEM pipeline register; a bubble clears only control, data may stay stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_r   <= '0;
      result_r <= '0;
      store_r  <= '0;
    end else if (bus.flush) begin
      ctrl_r.valid     <= 1'b0;
      ctrl_r.reg_write <= 1'b0;
      ctrl_r.mem_read  <= 1'b0;
      ctrl_r.mem_write <= 1'b0;
    end else if (bus.stall) begin
      ctrl_r   <= ctrl_r;
      result_r <= result_r;
      store_r  <= store_r;
    end else begin
      ctrl_r.valid     <= bus.ex_valid;
      ctrl_r.rd        <= bus.ex_rd;
      ctrl_r.reg_write <= bus.ex_reg_write & bus.ex_valid;
      ctrl_r.mem_read  <= bus.ex_mem_read  & bus.ex_valid;
      ctrl_r.mem_write <= bus.ex_mem_write & bus.ex_valid;
      result_r         <= bus.alu_result;
      store_r          <= bus.ex_store_data;
    end
  end

  assign bus.ex_zero        = ex_zero;
  assign bus.flags          = flags_r;
  assign bus.mem_valid      = ctrl_r.valid;
  assign bus.mem_rd         = ctrl_r.rd[REG_BITS-1:0];
  assign bus.mem_reg_write  = ctrl_r.reg_write;
  assign bus.mem_mem_read   = ctrl_r.mem_read;
  assign bus.mem_mem_write  = ctrl_r.mem_write;
  assign bus.mem_result     = result_r;
  assign bus.mem_store_data = store_r;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed self-checking bench for ex_mem_flag_stage.
module tb_ex_mem_flag_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ex_mem_flag_stage_if #(.WIDTH(64), .REG_BITS(5)) bus ();

  ex_mem_flag_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] res, input logic cout, input logic cin,
                       input logic [2:0] sel, input logic valid, input logic setf,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic [63:0] sd);
    bus.alu_result    = res;
    bus.alu_cout_msb  = cout;
    bus.alu_cin_msb   = cin;
    bus.alu_select    = sel;
    bus.ex_valid      = valid;
    bus.ex_set_flags  = setf;
    bus.ex_rd         = rd;
    bus.ex_reg_write  = rw;
    bus.ex_mem_read   = mr;
    bus.ex_mem_write  = mw;
    bus.ex_store_data = sd;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(64'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0);
    repeat (2) tick();
    check("reset_flags", bus.flags, 64'h0);
    check("reset_mem_valid", bus.mem_valid, 64'h0);
    check("reset_mem_result", bus.mem_result, 64'h0);
    reset = 1'b0;

    // ADDS wrap-around 0x7FFF..F + 1
    drive(64'h8000_0000_0000_0000, 1'b0, 1'b1, 3'b010, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 64'hA5);
    #1;
    check("adds_wrap_fwd", bus.flags_fwd, 64'h9);
    check("adds_wrap_zero", bus.ex_zero, 64'h0);
    check("adds_wrap_flags_before", bus.flags, 64'h0);
    tick();
    check("adds_wrap_flags", bus.flags, 64'h9);
    check("adds_wrap_result", bus.mem_result, 64'h8000_0000_0000_0000);
    check("adds_wrap_valid", bus.mem_valid, 64'h1);
    check("adds_wrap_rd", bus.mem_rd, 64'h3);
    check("adds_wrap_rw", bus.mem_reg_write, 64'h1);
    check("adds_wrap_sd", bus.mem_store_data, 64'hA5);

    // SUBS 5-5
    drive(64'h0, 1'b1, 1'b1, 3'b011, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 64'h0);
    #1;
    check("subs_zero", bus.ex_zero, 64'h1);
    check("subs_fwd", bus.flags_fwd, 64'h6);
    tick();
    check("subs_flags", bus.flags, 64'h6);

    // ANDS with zero result; carry inputs must be ignored
    drive(64'h0, 1'b1, 1'b0, 3'b100, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 64'h0);
    #1;
    check("ands_fwd", bus.flags_fwd, 64'h4);
    tick();
    check("ands_flags", bus.flags, 64'h4);

    // ADD without set_flags, result 0
    drive(64'h0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 64'h77);
    #1;
    check("add_nf_zero", bus.ex_zero, 64'h1);
    check("add_nf_fwd", bus.flags_fwd, 64'h4);
    tick();
    check("add_nf_flags", bus.flags, 64'h4);
    check("add_nf_result", bus.mem_result, 64'h0);
    check("add_nf_valid", bus.mem_valid, 64'h1);
    check("add_nf_mr", bus.mem_mem_read, 64'h1);

    // Two-cycle stall with a flag-setting store in EX
    drive(64'h10, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 64'h1234);
    bus.stall = 1'b1;
    #1;
    check("stall_fwd", bus.flags_fwd, 64'h0);
    repeat (2) tick();
    check("stall_flags", bus.flags, 64'h4);
    check("stall_result", bus.mem_result, 64'h0);
    check("stall_rd", bus.mem_rd, 64'h6);
    check("stall_sd", bus.mem_store_data, 64'h77);
    check("stall_mw", bus.mem_mem_write, 64'h0);
    bus.stall = 1'b0;
    tick();
    check("release_flags", bus.flags, 64'h0);
    check("release_result", bus.mem_result, 64'h10);
    check("release_rd", bus.mem_rd, 64'h7);
    check("release_mw", bus.mem_mem_write, 64'h1);
    check("release_rw", bus.mem_reg_write, 64'h0);
    check("release_sd", bus.mem_store_data, 64'h1234);
    bus.ex_valid = 1'b0;
    tick();
    check("bubble_valid", bus.mem_valid, 64'h0);
    check("bubble_mw", bus.mem_mem_write, 64'h0);

    // ORS-style flag setter with N=1, then stall+flush together
    drive(64'h8000_0000_0000_0055, 1'b1, 1'b0, 3'b101, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    check("or_flags", bus.flags, 64'h8);
    check("or_valid", bus.mem_valid, 64'h1);
    drive(64'h0, 1'b1, 1'b1, 3'b010, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 64'h0);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    check("sf_valid", bus.mem_valid, 64'h0);
    check("sf_rw", bus.mem_reg_write, 64'h0);
    check("sf_flags", bus.flags, 64'h8);
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // Load live state, then assert reset mid-cycle
    drive(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 5'd11, 1'b1, 1'b1, 1'b1, 64'hBEEF);
    tick();
    check("pre_reset_flags", bus.flags, 64'h3);
    check("pre_reset_valid", bus.mem_valid, 64'h1);
    bus.stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_flags", bus.flags, 64'h0);
    check("mid_reset_valid", bus.mem_valid, 64'h0);
    check("mid_reset_rd", bus.mem_rd, 64'h0);
    check("mid_reset_ctrl", {bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write}, 64'h0);
    check("mid_reset_result", bus.mem_result, 64'h0);
    check("mid_reset_sd", bus.mem_store_data, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.stall = 1'b0;
    drive(64'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    check("post_reset_flags", bus.flags, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
